// File: rtl/lc3x_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : lc3x_muldiv_unit
// Description : Multi-cycle signed/unsigned multiply/divide unit for the
//               LC-3x EX stage (fixed-latency multiply, restoring divide).
// Revision    : 1.0 - initial release
// ============================================================================
module lc3x_muldiv_unit #(
    parameter int WIDTH       = 16,
    parameter int MUL_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int c_cnt_max = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_LATENCY - 2);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic               w_accept;
    logic               w_dbz;
    logic               w_mul_fin;
    logic               w_div_fin;

    logic [c_cnt_w-1:0] r_count;
    logic               r_sel_hi;
    logic               r_signed;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_mag_b;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a_in;
    logic [WIDTH-1:0]   w_mag_b_in;

    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_fin;
    logic [WIDTH-1:0]   w_rem_fin;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        w_accept     = 1'b0;
        w_dbz        = 1'b0;
        w_mul_fin    = 1'b0;
        w_div_fin    = 1'b0;
        if (rst || flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        stall    = 1'b1;
                        w_accept = 1'b1;
                        if (!op[1]) begin
                            w_next_state = MUL;
                        end else if (b == '0) begin
                            w_dbz        = 1'b1;
                            w_next_state = DONE;
                        end else begin
                            w_next_state = DIV;
                        end
                    end
                end
                MUL: begin
                    stall = 1'b1;
                    if (r_count == c_mul_last) begin
                        w_mul_fin    = 1'b1;
                        w_next_state = DONE;
                    end
                end
                DIV: begin
                    stall = 1'b1;
                    if (r_count == c_div_last) begin
                        w_div_fin    = 1'b1;
                        w_next_state = DONE;
                    end
                end
                DONE: begin
                    w_next_state = IDLE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign done = (r_state == DONE);

    // ------------------------------------------------------------------
    // Operand conditioning at capture time
    // ------------------------------------------------------------------
    assign w_a_neg    = is_signed & a[WIDTH-1];
    assign w_b_neg    = is_signed & b[WIDTH-1];
    assign w_mag_a_in = w_a_neg ? (~a + 1'b1) : a;
    assign w_mag_b_in = w_b_neg ? (~b + 1'b1) : b;

    // Sign/zero extension to 2*WIDTH makes one modular multiply serve both modes
    assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // ------------------------------------------------------------------
    // One restoring-division step on the magnitudes
    // ------------------------------------------------------------------
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_mag_b});

    always_comb begin
        w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
        w_rem_nxt = w_shift[WIDTH-1:0];
        if (w_fits) begin
            // Difference is below the divisor, so it fits in WIDTH bits
            w_rem_nxt = w_shift[WIDTH-1:0] - r_mag_b;
        end
    end

    assign w_quo_fin = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_rem_fin = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_sel_hi    <= 1'b0;
            r_signed    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_mag_b     <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_sel_hi <= op[0];
            r_signed <= is_signed;
            r_a      <= a;
            r_b      <= b;
            r_quo    <= w_mag_a_in;
            r_rem    <= '0;
            r_mag_b  <= w_mag_b_in;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_dbz) begin
                result      <= op[0] ? a : '1;
                div_by_zero <= 1'b1;
            end
        end else if (r_state == MUL || r_state == DIV) begin
            r_count <= r_count + 1'b1;
            if (r_state == DIV) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
            end
            if (w_mul_fin) begin
                result      <= r_sel_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
            if (w_div_fin) begin
                result      <= r_sel_hi ? w_rem_fin : w_quo_fin;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3x_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lc3x_muldiv_unit
// Description : Scoreboard bench for lc3x_muldiv_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3x_muldiv_unit;

    localparam int W  = 16;
    localparam int ML = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         start;
    logic [1:0]   op;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    always #5 clk = ~clk;

    lc3x_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .start       (start),
        .op          (op),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .stall       (stall),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           cyc    = 0;
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] last_res = '0;
    logic         last_dbz = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: plain integer multiply/divide on sign- or zero-extended operands
    function automatic exp_t model(input logic [1:0] o, input bit s, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint p;
        e.dbz = 1'b0;
        e.cyc = 0;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        case (o)
            2'd0: e.res = W'(p);
            2'd1: e.res = W'(p >>> W);
            2'd2: e.res = (y == 0) ? {W{1'b1}} : W'(sx / sy);
            default: e.res = (y == 0) ? x : W'(sx % sy);
        endcase
        if (o >= 2'd2 && y == 0) e.dbz = 1'b1;
        return e;
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [W-1:0] y);
        if (o < 2'd2) return ML;
        if (y == 0)   return 1;
        return W + 1;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected completion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("result", result, e.res);
                    check("div_by_zero", div_by_zero, e.dbz);
                    check("done_cycle", cyc, e.cyc);
                    last_res = e.res;
                    last_dbz = e.dbz;
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input bit s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit keep, input bit scramble);
        exp_t e;
        bit   seen;
        int   bad_stall;
        if (done === 1'b1) @(posedge clk);
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        is_signed = s;
        a         = x;
        b         = y;
        e         = model(o, s, x, y);
        e.cyc     = cyc + latency(o, y);
        sbq.push_back(e);
        #1 check("stall_cycle0", stall, 1);
        seen      = 1'b0;
        bad_stall = 0;
        for (int n = 0; n < W + 8 && !seen; n++) begin
            @(posedge clk);
            #2;
            if (done === 1'b1) begin
                seen = 1'b1;
                check("stall_at_done", stall, 0);
            end else begin
                if (stall !== 1'b1) bad_stall++;
                if (scramble) begin
                    a = W'($urandom);
                    b = W'($urandom);
                end
            end
        end
        check("stall_before_done", bad_stall, 0);
        check("done_seen", seen, 1);
        if (!keep) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           pick;

        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 2'd0; is_signed = 1'b0;
        a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;

        run_op(2'd0, 1, 16'h0007, 16'hFFFD, 0, 0);
        run_op(2'd1, 1, 16'h4000, 16'h0004, 0, 0);
        run_op(2'd1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
        run_op(2'd0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
        run_op(2'd2, 0, 16'd100,  16'd7,    0, 0);
        run_op(2'd3, 0, 16'd100,  16'd7,    0, 0);
        run_op(2'd2, 1, 16'hFFF9, 16'h0002, 0, 0);
        run_op(2'd3, 1, 16'hFFF9, 16'h0002, 0, 0);
        run_op(2'd2, 0, 16'h1234, 16'h0000, 0, 0);
        run_op(2'd3, 1, 16'h1234, 16'h0000, 0, 0);
        run_op(2'd2, 1, 16'h8000, 16'hFFFF, 0, 0);
        run_op(2'd3, 1, 16'h8000, 16'hFFFF, 0, 1);

        // Flush a divide in its fifth cycle
        @(negedge clk);
        start = 1'b1; op = 2'd2; is_signed = 1'b0; a = 16'd100; b = 16'd7;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        #1 check("flush_stall", stall, 0);
        @(posedge clk);
        #2;
        check("flush_no_done", done, 0);
        check("flush_result_held", result, last_res);
        check("flush_dbz_held", div_by_zero, last_dbz);
        flush = 1'b0;
        run_op(2'd0, 0, 16'd3, 16'd5, 0, 0);

        // Flush and start together in IDLE: nothing may be captured
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'd0; a = 16'd9; b = 16'd9;
        #1 check("flush_start_stall", stall, 0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        repeat (ML + 2) @(negedge clk);
        check("flush_start_result", result, 16'h000F);

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 2'd0; is_signed = 1'b0; a = 16'd7; b = 16'd9;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        #1 check("midrst_stall", stall, 0);
        @(posedge clk);
        #2;
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_dbz", div_by_zero, 0);
        last_res = '0;
        last_dbz = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (ML + 2) @(negedge clk);

        // Back-to-back multiplies: start held through DONE
        run_op(2'd0, 0, 16'd11, 16'd13, 1, 0);
        run_op(2'd0, 1, 16'hFFFE, 16'd21, 0, 0);

        for (int i = 0; i < 150; i++) begin
            ro   = 2'($urandom);
            ra   = W'($urandom);
            rb   = W'($urandom);
            pick = $urandom_range(0, 9);
            if (pick == 0) rb = '0;
            if (pick == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
            if (pick == 2) rb = W'($urandom_range(1, 3));
            run_op(ro, 1'($urandom), ra, rb, 1'($urandom), 1'($urandom));
        end

        start = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
